// File: rtl/data_ram_arbiter_if.sv
// Purpose : request/grant data bus between a master and a RAM-style slave.
// Latency : n/a (signal bundle only).
// Backpr. : master holds req/we/be/addr/wdata until gnt; rvalid/rdata/err follow one cycle after gnt.
//
// Signals: req, we, be[3:0], addr[31:0], wdata[31:0] (master -> slave)
//          gnt, rvalid, rdata[31:0], err              (slave -> master)
interface bus_if;
    logic        req;
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;
    logic        err;

    modport master (output req, we, be, addr, wdata, input gnt, rvalid, rdata, err);
    modport slave  (input req, we, be, addr, wdata, output gnt, rvalid, rdata, err);
endinterface

// File: rtl/data_ram_arbiter.sv
// Purpose : round-robin share of the single data-RAM port between N_MASTERS bus masters,
//           with local error responses for accesses outside the RAM window.
// Latency : gnt combinational in the request cycle; rvalid/rdata/err exactly one cycle later.
// Backpr. : losers see gnt=0 and hold their request; the winner is stalled only by s_bus.gnt.
//
// Ports:
//   clk_i, rst_ni      clock, asynchronous active-low reset
//   m_bus[N_MASTERS]   master-side ports (bus_if.slave)
//   s_bus              port towards the data RAM wrapper (bus_if.master)
//   perf_clr_i         synchronous clear of the performance counters      (DATA_RAM_ARB_PERF_EN)
//   perf_gnt_o         per-master grant counters, saturating              (DATA_RAM_ARB_PERF_EN)
//   perf_conflict_o    count of cycles with two or more requests pending  (DATA_RAM_ARB_PERF_EN)
// Optional feature macro: DATA_RAM_ARB_PERF_EN (undefined: no perf ports, no counters).
module data_ram_arbiter #(
    parameter int N_MASTERS = 2,
    parameter int ADDR_W    = 16
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    bus_if.slave                       m_bus [N_MASTERS],
    bus_if.master                      s_bus
`ifdef DATA_RAM_ARB_PERF_EN
    ,
    input  logic                       perf_clr_i,
    output logic [N_MASTERS-1:0][31:0] perf_gnt_o,
    output logic [31:0]                perf_conflict_o
`endif
);
    localparam int IDX_W = (N_MASTERS > 1) ? $clog2(N_MASTERS) : 1;
    // One extra bit so pointer + offset can be wrapped without overflow.
    localparam int CW    = IDX_W + 1;

    logic [N_MASTERS-1:0]       m_req, m_we, m_gnt, m_rvalid, m_err;
    logic [N_MASTERS-1:0][3:0]  m_be;
    logic [N_MASTERS-1:0][31:0] m_addr, m_wdata, m_rdata;

    for (genvar g = 0; g < N_MASTERS; g++) begin : g_port
        assign m_req[g]        = m_bus[g].req;
        assign m_we[g]         = m_bus[g].we;
        assign m_be[g]         = m_bus[g].be;
        assign m_addr[g]       = m_bus[g].addr;
        assign m_wdata[g]      = m_bus[g].wdata;
        assign m_bus[g].gnt    = m_gnt[g];
        assign m_bus[g].rvalid = m_rvalid[g];
        assign m_bus[g].rdata  = m_rdata[g];
        assign m_bus[g].err    = m_err[g];
    end

    logic [IDX_W-1:0] rr_last_q, rr_last_d;
    logic [IDX_W-1:0] owner_q, owner_d;
    logic             owner_vld_q, owner_vld_d;
    logic             err_pend_q, err_pend_d;

    logic [IDX_W-1:0] win_idx;
    logic             win_vld, win_oor, grant;
    logic [CW-1:0]    cand;
    logic             s_req;

    // Round-robin search starting just after the last granted master.
    always_comb begin
        win_vld = 1'b0;
        win_idx = '0;
        cand    = '0;
        for (int i = 1; i <= N_MASTERS; i++) begin
            cand = CW'(rr_last_q) + CW'(i);
            if (cand >= CW'(N_MASTERS)) begin
                cand = cand - CW'(N_MASTERS);
            end
            if (!win_vld && m_req[cand[IDX_W-1:0]]) begin
                win_vld = 1'b1;
                win_idx = cand[IDX_W-1:0];
            end
        end
    end

    // Out-of-window winners are granted locally and never reach the RAM.
    always_comb begin
        win_oor = win_vld && (m_addr[win_idx][31:ADDR_W] != '0);
        s_req   = win_vld && !win_oor;
        grant   = win_vld && (win_oor || s_bus.gnt);
        m_gnt   = '0;
        if (win_vld) begin
            m_gnt[win_idx] = win_oor || s_bus.gnt;
        end
    end

    assign s_bus.req   = s_req;
    assign s_bus.we    = s_req && m_we[win_idx];
    assign s_bus.be    = s_req ? m_be[win_idx]    : 4'b0000;
    assign s_bus.addr  = s_req ? m_addr[win_idx]  : 32'h0;
    assign s_bus.wdata = s_req ? m_wdata[win_idx] : 32'h0;

    always_comb begin
        rr_last_d   = grant ? win_idx : rr_last_q;
        owner_d     = grant ? win_idx : owner_q;
        owner_vld_d = grant;
        err_pend_d  = grant && win_oor;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rr_last_q   <= IDX_W'(N_MASTERS - 1);
            owner_q     <= '0;
            owner_vld_q <= 1'b0;
            err_pend_q  <= 1'b0;
        end else begin
            rr_last_q   <= rr_last_d;
            owner_q     <= owner_d;
            owner_vld_q <= owner_vld_d;
            err_pend_q  <= err_pend_d;
        end
    end

    // The response belongs to whoever was granted last cycle, not to this cycle's winner.
    always_comb begin
        m_rvalid = '0;
        m_err    = '0;
        m_rdata  = '0;
        for (int i = 0; i < N_MASTERS; i++) begin
            if (owner_vld_q && (owner_q == IDX_W'(i))) begin
                m_rvalid[i] = s_bus.rvalid || err_pend_q;
                m_err[i]    = err_pend_q || s_bus.err;
                m_rdata[i]  = err_pend_q ? 32'h0 : s_bus.rdata;
            end
        end
    end

`ifdef DATA_RAM_ARB_PERF_EN
    logic [N_MASTERS-1:0][31:0] perf_gnt_q, perf_gnt_d;
    logic [31:0]                perf_conf_q, perf_conf_d;
    logic [3:0]                 req_cnt;

    always_comb begin
        req_cnt = '0;
        for (int i = 0; i < N_MASTERS; i++) begin
            req_cnt = req_cnt + 4'(m_req[i]);
        end
        perf_gnt_d  = perf_gnt_q;
        perf_conf_d = perf_conf_q;
        for (int i = 0; i < N_MASTERS; i++) begin
            if (grant && (win_idx == IDX_W'(i)) && (perf_gnt_q[i] != 32'hFFFF_FFFF)) begin
                perf_gnt_d[i] = perf_gnt_q[i] + 32'd1;
            end
        end
        if ((req_cnt >= 4'd2) && (perf_conf_q != 32'hFFFF_FFFF)) begin
            perf_conf_d = perf_conf_q + 32'd1;
        end
        if (perf_clr_i) begin
            perf_gnt_d  = '0;
            perf_conf_d = '0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            perf_gnt_q  <= '0;
            perf_conf_q <= '0;
        end else begin
            perf_gnt_q  <= perf_gnt_d;
            perf_conf_q <= perf_conf_d;
        end
    end

    assign perf_gnt_o      = perf_gnt_q;
    assign perf_conflict_o = perf_conf_q;
`endif
endmodule
